switch_op_select: RTL and testbench



---
 rtl/switch_op_select.sv | 118 +++++++++++
 tb/tb_switch_op_select.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_op_select.sv
// Operator-select front end: synchronises and debounces the DIP switches, decodes a one-hot
// operator and offers each new operator to the calculator control FSM over a valid/ack handshake.
module switch_op_select #(
    parameter int N_SW            = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_MODE       = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] i_sw_dip,
    input  logic            i_op_ack,
    output logic [N_SW-1:0] o_led,
    output logic [7:0]      o_lcd,
    output logic [3:0]      o_op,
    output logic            o_op_valid,
    output logic            o_err,
    output logic            o_overrun
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] LCD_BLANK = 8'h20;

    logic [N_SW-1:0]  sync1, sync2, cand, stable;
    logic [CNT_W-1:0] cnt;

    logic            multi_hot, legal, new_event;
    logic [3:0]      sel_code, nxt_op;
    logic [N_SW-1:0] nxt_led;
    logic [7:0]      nxt_lcd;

    function automatic logic [7:0] lcd_char(input logic [3:0] code);
        case (code)
            4'd1:    return 8'h2B;
            4'd2:    return 8'h2D;
            4'd3:    return 8'hD7;
            4'd4:    return 8'h2F;
            4'd5:    return 8'hF7;
            4'd6:    return 8'h5E;
            4'd7:    return 8'h21;
            4'd8:    return 8'h3D;
            default: return LCD_BLANK;
        endcase
    endfunction

    // Switch bit i selects operator N_SW-1-i, whose code is one higher.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
        // which is what would otherwise infer a latch.
        sel_code  = 4'd0;
        multi_hot = (stable & (stable - N_SW'(1))) != '0;
        legal     = (stable != '0) && !multi_hot;
        for (int i = 0; i < N_SW; i++) begin
            if (stable[i]) sel_code = 4'(N_SW - i);
        end
    end

    always_comb begin
        nxt_led = o_led;
        nxt_lcd = o_lcd;
        nxt_op  = o_op;
        if (legal) begin
            nxt_led = stable;
            nxt_op  = sel_code;
            nxt_lcd = lcd_char(sel_code);
        end else if (HOLD_MODE == 0) begin
            nxt_led = '0;
            nxt_op  = 4'd0;
            nxt_lcd = LCD_BLANK;
        end
        new_event = (nxt_op != 4'd0) && (nxt_op != o_op);
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            cand       <= '0;
            stable     <= '0;
            cnt        <= '0;
            o_led      <= '0;
            o_lcd      <= LCD_BLANK;
            o_op       <= 4'd0;
            o_op_valid <= 1'b0;
            o_err      <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            sync1 <= i_sw_dip;
            sync2 <= sync1;

            // Any change restarts the window; cnt saturates once the candidate is accepted.
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                stable <= cand;
            end

            o_led <= nxt_led;
            o_lcd <= nxt_lcd;
            o_op  <= nxt_op;
            o_err <= multi_hot;

            if (new_event) begin
                o_op_valid <= 1'b1;
                o_overrun  <= o_op_valid && !i_op_ack;
            end else begin
                o_overrun <= 1'b0;
                if (i_op_ack) o_op_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_switch_op_select.sv
// Bench for switch_op_select: one instance per HOLD_MODE on shared stimulus, checked every cycle
// against a sample-window model, plus hand-computed literal expectations at key points.
module tb_switch_op_select;

    localparam int N_SW = 8;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       rst, ack;
    logic [7:0] sw;

    logic [7:0] led0, led1, lcd0, lcd1;
    logic [3:0] op0, op1;
    logic       v0, v1, e0, e1, ov0, ov1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    switch_op_select #(.N_SW(N_SW), .DEBOUNCE_CYCLES(DEB), .HOLD_MODE(0)) u_follow (
        .clk(clk), .rst(rst), .i_sw_dip(sw), .i_op_ack(ack),
        .o_led(led0), .o_lcd(lcd0), .o_op(op0), .o_op_valid(v0), .o_err(e0), .o_overrun(ov0)
    );

    switch_op_select #(.N_SW(N_SW), .DEBOUNCE_CYCLES(DEB), .HOLD_MODE(1)) u_hold (
        .clk(clk), .rst(rst), .i_sw_dip(sw), .i_op_ack(ack),
        .o_led(led1), .o_lcd(lcd1), .o_op(op1), .o_op_valid(v1), .o_err(e1), .o_overrun(ov1)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [7:0] led;
        logic [7:0] lcd;
        logic [3:0] op;
        logic       err;
        logic       valid;
        logic       ovr;
    } exp_t;

    exp_t       m [2];
    logic [7:0] m_stable;
    logic [7:0] hist[$];
    logic [7:0] lcd_tab [8];
    bit         model_ok = 0;

    initial lcd_tab = '{8'h2B, 8'h2D, 8'hD7, 8'h2F, 8'hF7, 8'h5E, 8'h21, 8'h3D};

    task automatic model_outputs(input int k, input bit hold);
        exp_t n;
        int   ones;
        int   j;
        n    = m[k];
        ones = $countones(m_stable);
        if (ones == 1) begin
            j = 0;
            for (int i = 0; i < N_SW; i++) if (m_stable[i]) j = N_SW - 1 - i;
            n.led = m_stable;
            n.op  = 4'(j + 1);
            n.lcd = lcd_tab[j];
        end else if (!hold) begin
            n.led = 8'h00;
            n.op  = 4'd0;
            n.lcd = 8'h20;
        end
        n.err = (ones > 1);
        if (n.op != 4'd0 && n.op != m[k].op) begin
            n.valid = 1'b1;
            n.ovr   = m[k].valid && !ack;
        end else begin
            n.ovr = 1'b0;
            if (ack) n.valid = 1'b0;
        end
        m[k] = n;
    endtask

    // A value is accepted once the raw samples taken DEB+1..2 edges ago all agree on it.
    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            for (int i = 0; i < DEB + 3; i++) hist.push_back(8'h00);
            m_stable = 8'h00;
            for (int k = 0; k < 2; k++) m[k] = '{8'h00, 8'h20, 4'd0, 1'b0, 1'b0, 1'b0};
            model_ok = 1;
        end else if (model_ok) begin
            model_outputs(0, 1'b0);
            model_outputs(1, 1'b1);
            hist.push_back(sw);
            void'(hist.pop_front());
            begin
                bit same;
                same = 1;
                for (int i = 1; i <= DEB; i++) if (hist[i] != hist[0]) same = 0;
                if (same) m_stable = hist[0];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (model_ok) begin
            check("follow.led", led0, m[0].led);
            check("follow.lcd", lcd0, m[0].lcd);
            check("follow.op", 8'(op0), 8'(m[0].op));
            check("follow.err", 8'(e0), 8'(m[0].err));
            check("follow.valid", 8'(v0), 8'(m[0].valid));
            check("follow.overrun", 8'(ov0), 8'(m[0].ovr));
            check("hold.led", led1, m[1].led);
            check("hold.lcd", lcd1, m[1].lcd);
            check("hold.op", 8'(op1), 8'(m[1].op));
            check("hold.err", 8'(e1), 8'(m[1].err));
            check("hold.valid", 8'(v1), 8'(m[1].valid));
            check("hold.overrun", 8'(ov1), 8'(m[1].ovr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        cycles(1);
        ack = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".op0"}, 8'(op0), 8'h00);
        check({tag, ".lcd0"}, lcd0, 8'h20);
        check({tag, ".led0"}, led0, 8'h00);
        check({tag, ".valid0"}, 8'(v0), 8'h00);
        check({tag, ".err0"}, 8'(e0), 8'h00);
        check({tag, ".ovr0"}, 8'(ov0), 8'h00);
        check({tag, ".op1"}, 8'(op1), 8'h00);
        check({tag, ".lcd1"}, lcd1, 8'h20);
        check({tag, ".valid1"}, 8'(v1), 8'h00);
    endtask

    initial begin
        rst = 1'b1;
        sw  = 8'h00;
        ack = 1'b0;
        cycles(2);
        check_reset_values("reset");
        rst = 1'b0;
        cycles(3);

        // First operator and its latency.
        sw = 8'h80;
        cycles(7);
        check("lat.before", 8'(op0), 8'h00);
        cycles(1);
        check("sum.op", 8'(op0), 8'h01);
        check("sum.lcd", lcd0, 8'h2B);
        check("sum.led", led0, 8'h80);
        check("sum.valid", 8'(v0), 8'h01);
        check("sum.hold_op", 8'(op1), 8'h01);
        ack_pulse();
        check("ack.valid0", 8'(v0), 8'h00);
        check("ack.valid1", 8'(v1), 8'h00);

        // Bounce shorter than the window never gets through.
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? 8'h10 : 8'h00;
            cycles(2);
        end
        check("bounce.op", 8'(op0), 8'h01);
        check("bounce.lcd", lcd0, 8'h2B);
        sw = 8'h10;
        cycles(7);
        check("div.before", 8'(op0), 8'h01);
        cycles(1);
        check("div.op", 8'(op0), 8'h04);
        check("div.lcd", lcd0, 8'h2F);
        check("div.valid1", 8'(v1), 8'h01);
        ack_pulse();

        // Multi-hot.
        sw = 8'h0C;
        cycles(8);
        check("multi.err0", 8'(e0), 8'h01);
        check("multi.op0", 8'(op0), 8'h00);
        check("multi.lcd0", lcd0, 8'h20);
        check("multi.led0", led0, 8'h00);
        check("multi.err1", 8'(e1), 8'h01);
        check("multi.op1", 8'(op1), 8'h04);
        check("multi.lcd1", lcd1, 8'h2F);
        sw = 8'h08;
        cycles(8);
        check("rem.op1", 8'(op1), 8'h05);
        check("rem.lcd1", lcd1, 8'hF7);
        check("rem.valid1", 8'(v1), 8'h01);
        ack_pulse();
        sw = 8'h0C;
        cycles(8);
        check("hold_multi.op1", 8'(op1), 8'h05);
        check("hold_multi.lcd1", lcd1, 8'hF7);
        check("hold_multi.err1", 8'(e1), 8'h01);
        check("hold_multi.valid1", 8'(v1), 8'h00);

        // Overrun without ack, then an event coincident with ack.
        sw = 8'h01;
        cycles(8);
        check("equ.op0", 8'(op0), 8'h08);
        check("equ.lcd0", lcd0, 8'h3D);
        check("equ.valid0", 8'(v0), 8'h01);
        sw = 8'h02;
        cycles(7);
        check("ovr.before", 8'(ov0), 8'h00);
        cycles(1);
        check("fac.op0", 8'(op0), 8'h07);
        check("fac.lcd0", lcd0, 8'h21);
        check("fac.valid0", 8'(v0), 8'h01);
        check("fac.ovr0", 8'(ov0), 8'h01);
        check("fac.ovr1", 8'(ov1), 8'h01);
        cycles(1);
        check("ovr.after", 8'(ov0), 8'h00);
        sw = 8'h40;
        cycles(7);
        ack = 1'b1;
        cycles(1);
        ack = 1'b0;
        check("sub.op0", 8'(op0), 8'h02);
        check("sub.lcd0", lcd0, 8'h2D);
        check("sub.valid0", 8'(v0), 8'h01);
        check("sub.ovr0", 8'(ov0), 8'h00);
        ack_pulse();
        check("sub.cleared", 8'(v0), 8'h00);

        // Return to the same operator via none.
        sw = 8'h04;
        cycles(8);
        check("pow.op0", 8'(op0), 8'h06);
        check("pow.op1", 8'(op1), 8'h06);
        ack_pulse();
        sw = 8'h00;
        cycles(8);
        check("none.op1", 8'(op1), 8'h06);
        check("none.lcd1", lcd1, 8'h5E);
        check("none.op0", 8'(op0), 8'h00);
        check("none.lcd0", lcd0, 8'h20);
        sw = 8'h04;
        cycles(8);
        check("again.valid0", 8'(v0), 8'h01);
        check("again.valid1", 8'(v1), 8'h00);
        ack_pulse();

        // Reset while an event is pending, switches held.
        sw = 8'h20;
        cycles(8);
        check("mul.valid0", 8'(v0), 8'h01);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check_reset_values("midreset");
        cycles(7);
        check("rearm.before", 8'(v0), 8'h00);
        cycles(1);
        check("rearm.valid0", 8'(v0), 8'h01);
        check("rearm.op0", 8'(op0), 8'h03);
        check("rearm.lcd0", lcd0, 8'hD7);
        check("rearm.led0", led0, 8'h20);
        check("rearm.valid1", 8'(v1), 8'h01);
        ack_pulse();
        cycles(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
